// File: rtl/cache_req_queue_pkg.sv
// Shared types for the cache request queue: FSM states, queued entry layout
// and the default bus widths that match the cache interface.
package cache_req_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_entry_t;

  localparam int ENTRY_W = $bits(req_entry_t);

endpackage

// File: rtl/cache_req_queue_if.sv
// CPU request/response and cache strobe bundle. The queue is the slave;
// the CPU plus cache environment is the master.
interface cache_req_queue_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_we;
  logic [DATA_W-1:0] rsp_rdata;
  logic              MemReadCpu;
  logic              MemWriteCpu;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] DataIn;
  logic              Stall;
  logic [DATA_W-1:0] DataOut;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, Stall, DataOut,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata,
           MemReadCpu, MemWriteCpu, Address, DataIn
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, Stall, DataOut,
    output req_ready, rsp_valid, rsp_we, rsp_rdata,
           MemReadCpu, MemWriteCpu, Address, DataIn
  );
endinterface

// File: rtl/cache_req_queue_req_fifo.sv
// Synchronous FIFO with first-word fall-through read data. Pushes when full
// and pops when empty are ignored.
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cache_req_queue.sv
// Buffers CPU load/store requests, issues them one at a time to the cache and
// returns a single-cycle response per request in arrival order.
module cache_req_queue
  import cache_req_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  cache_req_queue_if.slave     bus,
  output logic [CNT_W-1:0]     stall_cnt
);
  state_e                  state_q, state_d;
  logic                    rsp_we_q, rsp_we_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;

  logic                    push, pop;
  logic                    fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic [ENTRY_W-1:0]      fifo_rdata;
  req_entry_t              head;

  logic                    mem_rd, mem_wr;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_din;

  assign push = bus.req_valid && !fifo_full;
  assign head = req_entry_t'(fifo_rdata);

  req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.req_we, bus.req_addr, bus.req_wdata}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    stall_cnt_d = stall_cnt_q;
    pop         = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_din     = '0;
    unique case (state_q)
      // A push this edge lands in the head slot, so issue can start next cycle.
      IDLE: if (!fifo_empty || push) state_d = ISSUE;
      ISSUE: begin
        mem_rd   = !head.we;
        mem_wr   = head.we;
        mem_addr = head.addr;
        mem_din  = head.wdata;
        if (bus.Stall) begin
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
          pop         = 1'b1;
          rsp_we_d    = head.we;
          rsp_rdata_d = head.we ? '0 : bus.DataOut;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.req_ready   = !fifo_full;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_we      = rsp_we_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.MemReadCpu  = mem_rd;
  assign bus.MemWriteCpu = mem_wr;
  assign bus.Address     = mem_addr;
  assign bus.DataIn      = mem_din;
  assign stall_cnt       = stall_cnt_q;

  a_count_range: assert property (@(posedge CLK) fifo_count <= ($clog2(DEPTH)+1)'(DEPTH));

endmodule

// File: tb/tb_cache_req_queue.sv
// Randomised and directed bench for cache_req_queue against a queue-based
// reference model; outputs are compared every cycle on the falling edge.
module tb_cache_req_queue;
  localparam int DEPTH     = 4;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 5;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST;
  logic [CNT_W-1:0] stall_cnt;
  logic             follow;
  logic [DATA_W-1:0] dataout_r;

  cache_req_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cache_req_queue #(
    .DEPTH (DEPTH), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .CNT_W (CNT_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  always #5 CLK = ~CLK;

  // The cache stand-in can echo the presented address as load data.
  assign bus.DataOut = follow ? DATA_W'(bus.Address) : dataout_r;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } m_ent_t;

  m_ent_t            mq[$];
  bit                m_issuing, m_resp, m_acc;
  bit                m_rsp_we;
  logic [DATA_W-1:0] m_rsp_rdata;
  int                m_stall;

  always @(posedge CLK) begin
    int     sz;
    m_ent_t e;
    sz = mq.size();
    if (RST) begin
      mq.delete();
      m_issuing   = 0;
      m_resp      = 0;
      m_acc       = 0;
      m_rsp_we    = 0;
      m_rsp_rdata = '0;
      m_stall     = 0;
    end else begin
      m_acc = bus.req_valid && (sz < DEPTH);
      if (m_issuing) begin
        if (bus.Stall) begin
          if (m_stall < STALL_MAX) m_stall++;
        end else begin
          e           = mq.pop_front();
          m_rsp_we    = e.we;
          m_rsp_rdata = e.we ? '0 : bus.DataOut;
          m_issuing   = 0;
          m_resp      = 1;
        end
      end else if (m_resp) begin
        m_resp = 0;
      end else if (sz > 0 || m_acc) begin
        m_issuing = 1;
      end
      if (m_acc) begin
        e.we = bus.req_we; e.addr = bus.req_addr; e.wdata = bus.req_wdata;
        mq.push_back(e);
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("req_ready", bus.req_ready, mq.size() < DEPTH);
      check("rsp_valid", bus.rsp_valid, m_resp);
      if (m_resp) begin
        check("rsp_we", bus.rsp_we, m_rsp_we);
        check("rsp_rdata", bus.rsp_rdata, m_rsp_rdata);
      end
      check("MemReadCpu", bus.MemReadCpu, m_issuing && !mq[0].we);
      check("MemWriteCpu", bus.MemWriteCpu, m_issuing && mq[0].we);
      check("Address", bus.Address, m_issuing ? mq[0].addr : '0);
      check("DataIn", bus.DataIn, m_issuing ? mq[0].wdata : '0);
      check("stall_cnt", stall_cnt, m_stall);
    end
  end

  // ---------------- stimulus ----------------
  task automatic randomize_inputs(input bit with_reset);
    RST           = with_reset && ($urandom_range(0, 299) == 0);
    bus.req_valid = $urandom_range(0, 1);
    bus.req_we    = $urandom_range(0, 1);
    bus.req_addr  = ADDR_W'($urandom);
    bus.req_wdata = $urandom;
    bus.Stall     = ($urandom_range(0, 9) < 4);
    dataout_r     = $urandom;
  endtask

  logic [DATA_W-1:0] rsp_d[$];
  int                rsp_t[$];
  int                n_acc;
  int                n_pulse;

  initial begin
    RST = 1'b1; follow = 1'b0; dataout_r = '0;
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_wdata = '0; bus.Stall = 0;
    step();
    chk_en = 1;
    RST = 1'b0;
    for (int i = 0; i < 50; i++) begin randomize_inputs(0); step(); end

    // Test 1: two reset cycles in the middle of traffic
    RST = 1'b1; step(); step();
    RST = 1'b0; bus.req_valid = 0; bus.Stall = 0;
    check("t1_req_ready", bus.req_ready, 1'b1);
    check("t1_rd", bus.MemReadCpu, 1'b0);
    check("t1_wr", bus.MemWriteCpu, 1'b0);
    check("t1_addr", bus.Address, '0);
    check("t1_rsp_valid", bus.rsp_valid, 1'b0);
    check("t1_rsp_we", bus.rsp_we, 1'b0);
    check("t1_rsp_rdata", bus.rsp_rdata, '0);
    check("t1_stall_cnt", stall_cnt, '0);

    // Test 2: single load, no stall
    bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 10'h05A; dataout_r = 32'hDEADBEEF;
    step();
    bus.req_valid = 0;
    check("t2_addr", bus.Address, 10'h05A);
    check("t2_rd", bus.MemReadCpu, 1'b1);
    check("t2_no_rsp_yet", bus.rsp_valid, 1'b0);
    step();
    check("t2_rsp_valid", bus.rsp_valid, 1'b1);
    check("t2_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    check("t2_rsp_we", bus.rsp_we, 1'b0);
    step();
    check("t2_rsp_one_cycle", bus.rsp_valid, 1'b0);
    step();

    // Test 3: load held for four stalled ISSUE cycles
    bus.req_valid = 1; bus.req_addr = 10'h05A; bus.Stall = 1;
    step();
    bus.req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      check("t3_addr_stable", bus.Address, 10'h05A);
      check("t3_rd_stable", bus.MemReadCpu, 1'b1);
      step();
    end
    bus.Stall = 0;
    check("t3_still_issued", bus.MemReadCpu, 1'b1);
    step();
    check("t3_rsp_valid", bus.rsp_valid, 1'b1);
    check("t3_stall_cnt", stall_cnt, 5'd4);
    step(); step();

    // Test 4: fill the queue behind a stalled request, then drain in order
    follow = 1; bus.Stall = 1; n_acc = 0;
    bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 10'h001;
    for (int c = 0; c < 60; c++) begin
      if (c == 10) begin
        check("t4_full_not_ready", bus.req_ready, 1'b0);
        check("t4_head_addr", bus.Address, 10'h001);
        check("t4_head_rd", bus.MemReadCpu, 1'b1);
        bus.Stall = 0;
      end
      step();
      if (m_acc) begin
        n_acc++;
        if (n_acc == 5) bus.req_valid = 0;
        else bus.req_addr = ADDR_W'(n_acc + 1);
      end
      if (bus.rsp_valid) begin rsp_d.push_back(bus.rsp_rdata); rsp_t.push_back(c); end
    end
    check("t4_rsp_count", rsp_d.size(), 5);
    for (int i = 0; i < rsp_d.size() && i < 5; i++) begin
      check("t4_rsp_order", rsp_d[i], i + 1);
      if (i > 0) check("t4_rsp_spacing", rsp_t[i] - rsp_t[i-1], 3);
    end
    follow = 0;

    // Test 5: store
    bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 10'h3FF;
    bus.req_wdata = 32'h12345678; dataout_r = 32'hCAFEF00D;
    step();
    bus.req_valid = 0;
    check("t5_wr", bus.MemWriteCpu, 1'b1);
    check("t5_rd", bus.MemReadCpu, 1'b0);
    check("t5_addr", bus.Address, 10'h3FF);
    check("t5_din", bus.DataIn, 32'h12345678);
    step();
    check("t5_rsp_valid", bus.rsp_valid, 1'b1);
    check("t5_rsp_we", bus.rsp_we, 1'b1);
    check("t5_rsp_rdata", bus.rsp_rdata, '0);
    step(); step();

    // Test 6: reset during a stalled issue with two more queued
    bus.Stall = 1; bus.req_valid = 1; bus.req_we = 0;
    for (int i = 0; i < 3; i++) begin bus.req_addr = ADDR_W'(10'h100 + i); step(); end
    bus.req_valid = 0;
    check("t6_issuing", bus.MemReadCpu, 1'b1);
    RST = 1; step();
    RST = 0; bus.Stall = 0;
    check("t6_rd_cleared", bus.MemReadCpu, 1'b0);
    check("t6_addr_cleared", bus.Address, '0);
    check("t6_ready", bus.req_ready, 1'b1);
    n_pulse = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.rsp_valid) n_pulse++;
      step();
    end
    check("t6_no_stale_rsp", n_pulse, 0);
    bus.req_valid = 1; bus.req_addr = 10'h077; dataout_r = 32'h0000_55AA;
    step();
    bus.req_valid = 0;
    step();
    check("t6_new_rsp_valid", bus.rsp_valid, 1'b1);
    check("t6_new_rsp_rdata", bus.rsp_rdata, 32'h0000_55AA);
    step();

    // Random traffic including occasional resets
    for (int i = 0; i < 2000; i++) begin randomize_inputs(1); step(); end
    RST = 0; bus.req_valid = 0; bus.Stall = 0;
    for (int i = 0; i < 20; i++) step();

    // stall_cnt saturates at all-ones instead of wrapping
    bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 10'h0AA; bus.Stall = 1;
    step();
    bus.req_valid = 0;
    for (int i = 0; i < 40; i++) step();
    check("sat_stall_cnt", stall_cnt, 5'd31);
    bus.Stall = 0;
    for (int i = 0; i < 5; i++) step();
    check("sat_held", stall_cnt, 5'd31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
